// File: rtl/ad_ip_jesd204_tpl_dac_adapter_pkg.sv
// Shared types for the TPL DAC DMA adapter: FSM state encoding and counter width.
package ad_ip_jesd204_tpl_dac_adapter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_UNF   = 2'd3
    } adapter_state_t;

    localparam int unsigned UNF_CNT_W = 16;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_sample_conv.sv
// Combinational conversion of one D-bit DMA sample to a B-bit link sample:
// padding side, optional saturation, channel-enable masking, offset-binary format.
module ad_ip_jesd204_tpl_dac_sample_conv #(
    parameter int unsigned D = 16,
    parameter int unsigned B = 16
) (
    input  logic [D-1:0] sample,
    input  logic         enable,
    input  logic         pad_msb,
    input  logic         sat,
    input  logic         fmt_ob,
    output logic [B-1:0] conv
);

    logic [B-1:0] raw;
    logic         in_range;

    always_comb begin
        // Bits D-1..B-1 all equal means the signed value fits in B bits;
        // with D == B this is a single bit, so saturation never triggers.
        in_range = (&sample[D-1:B-1]) | ~(|sample[D-1:B-1]);
        raw      = sample[D-1 -: B];
        if (pad_msb) begin
            raw = sample[B-1:0];
            if (sat && !in_range) begin
                raw = sample[D-1] ? {1'b1, {(B-1){1'b0}}} : {1'b0, {(B-1){1'b1}}};
            end
        end
    end

    always_comb begin
        conv      = enable ? raw : '0;
        conv[B-1] = conv[B-1] ^ fmt_ob;
    end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_dma_adapter.sv
// DMA-to-TPL DAC adapter: beat FIFO, prime/run/underflow FSM, per-sample conversion.
// Define AD_IP_JESD204_TPL_DAC_DMA_ADAPTER_UNF_COUNT_EN to add the unf_count port and counter.
module ad_ip_jesd204_tpl_dac_dma_adapter
    import ad_ip_jesd204_tpl_dac_adapter_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS        = 2,
    parameter int unsigned DATA_PATH_WIDTH     = 2,
    parameter int unsigned BITS_PER_SAMPLE     = 16,
    parameter int unsigned DMA_BITS_PER_SAMPLE = 16,
    parameter int unsigned FIFO_DEPTH          = 4,
    localparam int unsigned NS = NUM_CHANNELS * DATA_PATH_WIDTH,
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                              link_clk,
    input  logic                              link_resetn,
    input  logic                              s_dma_valid,
    output logic                              s_dma_ready,
    input  logic [NS*DMA_BITS_PER_SAMPLE-1:0] s_dma_data,
    input  logic [NUM_CHANNELS-1:0]           enable,
    input  logic                              dac_valid,
    output logic [NS*BITS_PER_SAMPLE-1:0]     dac_data,
    output logic                              dac_dunf,
    output logic                              dac_unf_sticky,
    input  logic                              unf_clear,
    input  logic                              cfg_pad_msb,
    input  logic                              cfg_sat,
    input  logic                              cfg_fmt_ob,
    input  logic                              cfg_unf_zero,
    input  logic [LW-1:0]                     cfg_prime_level,
    output logic [1:0]                        state
`ifdef AD_IP_JESD204_TPL_DAC_DMA_ADAPTER_UNF_COUNT_EN
    ,
    output logic [UNF_CNT_W-1:0]              unf_count
`endif
);

    localparam int unsigned D  = DMA_BITS_PER_SAMPLE;
    localparam int unsigned B  = BITS_PER_SAMPLE;
    localparam int unsigned AW = LW - 1;

    logic [NS*D-1:0] mem [FIFO_DEPTH];
    logic [NS*D-1:0] rd_beat;
    logic [NS*B-1:0] conv_beat;
    logic [LW-1:0]   wr_ptr, rd_ptr, fill, level;
    logic            ready_en, any_en, empty, full, push, pop, unf_evt;
    adapter_state_t  state_q, state_d;

    always_comb begin
        any_en      = |enable;
        fill        = wr_ptr - rd_ptr;
        empty       = (fill == '0);
        full        = (fill == LW'(FIFO_DEPTH));
        s_dma_ready = ready_en & ~full;
        push        = s_dma_valid & s_dma_ready & any_en;
        pop         = any_en & dac_valid & (state_q == ST_RUN) & ~empty;
        unf_evt     = any_en & dac_valid &
                      (((state_q == ST_RUN) & empty) | (state_q == ST_UNF));
        rd_beat     = mem[rd_ptr[AW-1:0]];
        state       = state_q;
        level       = cfg_prime_level;
        if (cfg_prime_level == '0) begin
            level = LW'(1);
        end else if (cfg_prime_level > LW'(FIFO_DEPTH)) begin
            level = LW'(FIFO_DEPTH);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_PRIME;
            ST_PRIME: if (fill >= level) state_d = ST_RUN;
            ST_RUN:   if (dac_valid && empty) state_d = ST_UNF;
            ST_UNF:   if (fill >= level) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
        if (!any_en) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge link_clk or negedge link_resetn) begin
        if (!link_resetn) begin
            state_q        <= ST_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            ready_en       <= 1'b0;
            dac_data       <= '0;
            dac_dunf       <= 1'b0;
            dac_unf_sticky <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_en <= 1'b1;
            // All channels disabled: drop queued beats and any same-cycle push.
            if (!any_en) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + LW'(1);
                if (pop)  rd_ptr <= rd_ptr + LW'(1);
            end
            if (!any_en) begin
                dac_data <= '0;
            end else if (pop) begin
                dac_data <= conv_beat;
            end else if (unf_evt && cfg_unf_zero) begin
                dac_data <= '0;
            end
            dac_dunf <= unf_evt;
            if (unf_evt) begin
                dac_unf_sticky <= 1'b1;
            end else if (unf_clear) begin
                dac_unf_sticky <= 1'b0;
            end
        end
    end

    always_ff @(posedge link_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= s_dma_data;
        end
    end

    for (genvar i = 0; i < NS; i++) begin : g_conv
        ad_ip_jesd204_tpl_dac_sample_conv #(
            .D (D),
            .B (B)
        ) i_conv (
            .sample  (rd_beat[i*D +: D]),
            .enable  (enable[i/DATA_PATH_WIDTH]),
            .pad_msb (cfg_pad_msb),
            .sat     (cfg_sat),
            .fmt_ob  (cfg_fmt_ob),
            .conv    (conv_beat[i*B +: B])
        );
    end

`ifdef AD_IP_JESD204_TPL_DAC_DMA_ADAPTER_UNF_COUNT_EN
    always_ff @(posedge link_clk or negedge link_resetn) begin
        if (!link_resetn) begin
            unf_count <= '0;
        end else if (unf_clear) begin
            unf_count <= unf_evt ? UNF_CNT_W'(1) : '0;
        end else if (unf_evt && unf_count != '1) begin
            unf_count <= unf_count + UNF_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_dma_adapter.sv
// Scoreboard bench for the TPL DAC DMA adapter (D=16, B=12, 2x2 samples, depth 4).
module tb_ad_ip_jesd204_tpl_dac_dma_adapter;

    localparam int DEPTH = 4;

    logic        link_clk, link_resetn;
    logic        s_dma_valid, s_dma_ready;
    logic [63:0] s_dma_data;
    logic [1:0]  enable;
    logic        dac_valid;
    logic [47:0] dac_data;
    logic        dac_dunf, dac_unf_sticky, unf_clear;
    logic        cfg_pad_msb, cfg_sat, cfg_fmt_ob, cfg_unf_zero;
    logic [2:0]  cfg_prime_level;
    logic [1:0]  state;
`ifdef AD_IP_JESD204_TPL_DAC_DMA_ADAPTER_UNF_COUNT_EN
    logic [15:0] unf_count;
`endif

    ad_ip_jesd204_tpl_dac_dma_adapter #(
        .NUM_CHANNELS        (2),
        .DATA_PATH_WIDTH     (2),
        .BITS_PER_SAMPLE     (12),
        .DMA_BITS_PER_SAMPLE (16),
        .FIFO_DEPTH          (DEPTH)
    ) dut (
        .link_clk        (link_clk),
        .link_resetn     (link_resetn),
        .s_dma_valid     (s_dma_valid),
        .s_dma_ready     (s_dma_ready),
        .s_dma_data      (s_dma_data),
        .enable          (enable),
        .dac_valid       (dac_valid),
        .dac_data        (dac_data),
        .dac_dunf        (dac_dunf),
        .dac_unf_sticky  (dac_unf_sticky),
        .unf_clear       (unf_clear),
        .cfg_pad_msb     (cfg_pad_msb),
        .cfg_sat         (cfg_sat),
        .cfg_fmt_ob      (cfg_fmt_ob),
        .cfg_unf_zero    (cfg_unf_zero),
        .cfg_prime_level (cfg_prime_level),
        .state           (state)
`ifdef AD_IP_JESD204_TPL_DAC_DMA_ADAPTER_UNF_COUNT_EN
        ,
        .unf_count       (unf_count)
`endif
    );

    initial begin
        link_clk = 1'b0;
        forever #5 link_clk = ~link_clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference conversion straight from the sample rules, in integer arithmetic.
    function automatic logic [11:0] ref_sample(input logic [15:0] s, input bit en,
                                               input bit pad, input bit sat, input bit ob);
        int          v;
        logic [11:0] x;
        v = $signed(s);
        if (!pad)                    x = 12'(s >> 4);
        else if (sat && v > 2047)    x = 12'h7FF;
        else if (sat && v < -2048)   x = 12'h800;
        else                         x = 12'(s & 16'h0FFF);
        if (!en) x = 12'h000;
        if (ob)  x = x ^ 12'h800;
        return x;
    endfunction

    function automatic logic [47:0] ref_beat(input logic [63:0] b, input logic [1:0] en,
                                             input bit pad, input bit sat, input bit ob);
        logic [47:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*12 +: 12] = ref_sample(b[i*16 +: 16], en[i/2], pad, sat, ob);
        end
        return r;
    endfunction

    function automatic logic [63:0] mk16(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [47:0] mk12(input logic [11:0] a, input logic [11:0] b,
                                         input logic [11:0] c, input logic [11:0] d);
        return {d, c, b, a};
    endfunction

    typedef struct {
        logic [47:0] data;
        logic        dunf;
        logic        sticky;
        logic        ready;
        logic [1:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model: a queue of beats plus the playout mode, evaluated per clock edge.
    localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_UNF = 3;
    logic [63:0] mq[$];
    int          m_mode;
    logic [47:0] m_data;
    bit          m_dunf, m_sticky, m_alive;
    int          m_cnt;

    initial begin
        int  fill, lvl;
        bit  ready_pre, unf, pop;
        exp_t e;
        forever begin
            @(posedge link_clk);
            if (!link_resetn) begin
                mq.delete();
                m_mode = M_IDLE; m_data = '0; m_dunf = 0; m_sticky = 0; m_cnt = 0; m_alive = 0;
            end else begin
                ready_pre = m_alive && (mq.size() < DEPTH);
                m_alive   = 1;
                fill      = mq.size();
                lvl       = (cfg_prime_level == 0) ? 1 :
                            (int'(cfg_prime_level) > DEPTH ? DEPTH : int'(cfg_prime_level));
                unf       = 0;
                if (enable == 2'b00) begin
                    mq.delete();
                    m_mode = M_IDLE;
                    m_data = '0;
                end else begin
                    unf = dac_valid && ((m_mode == M_RUN && fill == 0) || m_mode == M_UNF);
                    pop = dac_valid && m_mode == M_RUN && fill > 0;
                    if (pop)
                        m_data = ref_beat(mq.pop_front(), enable, cfg_pad_msb, cfg_sat, cfg_fmt_ob);
                    else if (unf && cfg_unf_zero)
                        m_data = '0;
                    case (m_mode)
                        M_IDLE:  m_mode = M_PRIME;
                        M_PRIME: if (fill >= lvl) m_mode = M_RUN;
                        M_RUN:   if (dac_valid && fill == 0) m_mode = M_UNF;
                        default: if (fill >= lvl) m_mode = M_RUN;
                    endcase
                    if (s_dma_valid && ready_pre) mq.push_back(s_dma_data);
                end
                m_dunf = unf;
                if (unf) m_sticky = 1;
                else if (unf_clear) m_sticky = 0;
                if (unf_clear) m_cnt = unf ? 1 : 0;
                else if (unf && m_cnt < 65535) m_cnt++;
            end
            e.data   = m_data;
            e.dunf   = m_dunf;
            e.sticky = m_sticky;
            e.ready  = m_alive && (mq.size() < DEPTH);
            e.st     = 2'(m_mode);
            e.cnt    = 16'(m_cnt);
            exp_q.push_back(e);
        end
    end

    // Monitor: compares DUT outputs against the queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge link_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_data",   64'(dac_data),       64'(e.data));
                chk("sb_dunf",   64'(dac_dunf),       64'(e.dunf));
                chk("sb_sticky", 64'(dac_unf_sticky), 64'(e.sticky));
                chk("sb_ready",  64'(s_dma_ready),    64'(e.ready));
                chk("sb_state",  64'(state),          64'(e.st));
`ifdef AD_IP_JESD204_TPL_DAC_DMA_ADAPTER_UNF_COUNT_EN
                chk("sb_count",  64'(unf_count),      64'(e.cnt));
`endif
            end
        end
    end

    task automatic tick();
        @(negedge link_clk);
    endtask

    // From RUN with an empty FIFO: push one beat, pop it, check the registered output.
    task automatic play(input string name, input logic [63:0] beat, input logic [47:0] exp);
        s_dma_valid = 1'b1; s_dma_data = beat;
        tick();
        s_dma_valid = 1'b0; dac_valid = 1'b1;
        tick();
        dac_valid = 1'b0;
        chk(name, 64'(dac_data), 64'(exp));
    endtask

    logic [63:0] x [6];
    logic [63:0] y [5];

    initial begin
        link_resetn = 1'b0; s_dma_valid = 1'b0; s_dma_data = '0; enable = 2'b00;
        dac_valid = 1'b0; unf_clear = 1'b0; cfg_pad_msb = 1'b1; cfg_sat = 1'b1;
        cfg_fmt_ob = 1'b0; cfg_unf_zero = 1'b0; cfg_prime_level = 3'd1;
        repeat (3) tick();
        chk("rst_ready",  64'(s_dma_ready),    64'd0);
        chk("rst_data",   64'(dac_data),       64'd0);
        chk("rst_state",  64'(state),          64'd0);
        chk("rst_dunf",   64'(dac_dunf),       64'd0);
        chk("rst_sticky", 64'(dac_unf_sticky), 64'd0);
        link_resetn = 1'b1;
        tick();

        // Conversion modes, level 1.
        enable = 2'b11; s_dma_valid = 1'b1;
        s_dma_data = mk16(16'h0900, 16'hF000, 16'h0123, 16'h0900);
        tick();
        s_dma_valid = 1'b0;
        tick();
        chk("lvl1_run", 64'(state), 64'd2);
        dac_valid = 1'b1;
        tick();
        dac_valid = 1'b0;
        chk("conv_sat", 64'(dac_data), 64'(mk12(12'h7FF, 12'h800, 12'h123, 12'h7FF)));
        cfg_sat = 1'b0;
        play("conv_nosat", mk16(16'h0900, 16'hF000, 16'h0123, 16'h8ABC),
             mk12(12'h900, 12'h000, 12'h123, 12'hABC));
        cfg_pad_msb = 1'b0;
        play("conv_lsbpad", mk16(16'hABCD, 16'h1234, 16'hFFFF, 16'h8000),
             mk12(12'hABC, 12'h123, 12'hFFF, 12'h800));
        cfg_fmt_ob = 1'b1; enable = 2'b01;
        play("conv_ob_dis", mk16(16'hABCD, 16'h1234, 16'h5678, 16'h9ABC),
             mk12(12'h2BC, 12'h923, 12'h800, 12'h800));

        // Priming to level 3 with dac_valid held high, then drain into underflow.
        enable = 2'b00;
        tick();
        enable = 2'b11; cfg_pad_msb = 1'b1; cfg_sat = 1'b1; cfg_fmt_ob = 1'b0;
        cfg_prime_level = 3'd3; dac_valid = 1'b1;
        for (int k = 0; k < 6; k++) x[k] = {$urandom, $urandom};
        s_dma_valid = 1'b1; s_dma_data = x[0];
        tick();
        s_dma_data = x[1];
        tick();
        chk("prime_state2", 64'(state),    64'd1);
        chk("prime_dunf",   64'(dac_dunf), 64'd0);
        chk("prime_data",   64'(dac_data), 64'd0);
        s_dma_data = x[2];
        tick();
        chk("prime_state3", 64'(state), 64'd1);
        s_dma_valid = 1'b0;
        tick();
        chk("prime_run",      64'(state),    64'd2);
        chk("prime_run_data", 64'(dac_data), 64'd0);
        tick();
        chk("first_sample", 64'(dac_data), 64'(ref_beat(x[0], 2'b11, 1, 1, 0)));
        tick();
        tick();
        chk("third_sample", 64'(dac_data), 64'(ref_beat(x[2], 2'b11, 1, 1, 0)));
        tick();
        chk("unf_pulse",  64'(dac_dunf),       64'd1);
        chk("unf_sticky", 64'(dac_unf_sticky), 64'd1);
        chk("unf_state",  64'(state),          64'd3);
        chk("unf_hold",   64'(dac_data),       64'(ref_beat(x[2], 2'b11, 1, 1, 0)));
        cfg_unf_zero = 1'b1;
        tick();
        chk("unf_zero", 64'(dac_data), 64'd0);
        dac_valid = 1'b0; cfg_unf_zero = 1'b0;
        tick();
        chk("unf_pulse_end", 64'(dac_dunf), 64'd0);
        s_dma_valid = 1'b1;
        for (int k = 3; k < 6; k++) begin
            s_dma_data = x[k];
            tick();
        end
        s_dma_valid = 1'b0;
        tick();
        chk("refill_run", 64'(state), 64'd2);

        // Full FIFO: a push offered while popping must be refused.
        cfg_prime_level = 3'd1; dac_valid = 1'b1;
        repeat (3) tick();
        dac_valid = 1'b0; s_dma_valid = 1'b1;
        for (int k = 0; k < 5; k++) y[k] = {$urandom, $urandom};
        for (int k = 0; k < 4; k++) begin
            s_dma_data = y[k];
            tick();
        end
        chk("full_ready", 64'(s_dma_ready), 64'd0);
        s_dma_data = y[4]; dac_valid = 1'b1;
        tick();
        s_dma_valid = 1'b0;
        chk("full_pop0", 64'(dac_data), 64'(ref_beat(y[0], 2'b11, 1, 1, 0)));
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("full_order", 64'(dac_data), 64'(ref_beat(y[k], 2'b11, 1, 1, 0)));
        end
        tick();
        chk("full_no_overwrite", 64'(dac_dunf), 64'd1);

        // Three more underflows, then clear coincident with a fourth.
        repeat (3) tick();
        unf_clear = 1'b1;
        tick();
        unf_clear = 1'b0; dac_valid = 1'b0;
        chk("clr_coinc_sticky", 64'(dac_unf_sticky), 64'd1);
`ifdef AD_IP_JESD204_TPL_DAC_DMA_ADAPTER_UNF_COUNT_EN
        chk("clr_coinc_count", 64'(unf_count), 64'd1);
`endif
        unf_clear = 1'b1;
        tick();
        unf_clear = 1'b0;
        chk("clr_sticky", 64'(dac_unf_sticky), 64'd0);

        // Disable mid-stream: IDLE next cycle and FIFO contents dropped.
        s_dma_valid = 1'b1; s_dma_data = {$urandom, $urandom};
        tick();
        s_dma_data = {$urandom, $urandom};
        tick();
        s_dma_valid = 1'b0; dac_valid = 1'b1;
        tick();
        enable = 2'b00; dac_valid = 1'b0;
        tick();
        chk("dis_state", 64'(state),       64'd0);
        chk("dis_data",  64'(dac_data),    64'd0);
        chk("dis_ready", 64'(s_dma_ready), 64'd1);
        enable = 2'b11; cfg_prime_level = 3'd2;
        s_dma_valid = 1'b1; s_dma_data = {$urandom, $urandom};
        tick();
        s_dma_valid = 1'b0;
        tick();
        chk("dis_flushed", 64'(state), 64'd1);

        // Randomised traffic with one reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                cfg_pad_msb     = 1'($urandom_range(0, 1));
                cfg_sat         = 1'($urandom_range(0, 1));
                cfg_fmt_ob      = 1'($urandom_range(0, 1));
                cfg_unf_zero    = 1'($urandom_range(0, 1));
                cfg_prime_level = 3'($urandom_range(0, 7));
            end
            enable      = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            s_dma_valid = ($urandom_range(0, 2) != 0);
            s_dma_data  = {$urandom, $urandom};
            dac_valid   = 1'($urandom_range(0, 1));
            unf_clear   = ($urandom_range(0, 15) == 0);
            link_resetn = !(c == 1500 || c == 1501);
            tick();
        end
        link_resetn = 1'b1; s_dma_valid = 1'b0; dac_valid = 1'b0; unf_clear = 1'b0;

        @(posedge link_clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
